// File: rtl/result_fifo_stage_pkg.sv
// Shared definitions for the 12-bit operand datapath: word width, word type
// and a helper that sizes FIFO pointers from a depth.
package result_fifo_stage_pkg;

  localparam int RES_WIDTH = 12;

  typedef logic [RES_WIDTH-1:0] result_word_t;

  // Number of address bits needed to index 'depth' entries (ceil(log2)).
  function automatic int ptr_w(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/result_fifo_stage_fifo_mem.sv
// Storage array for the result FIFO: one synchronous write port and an
// asynchronous read address. Deliberately has no reset; the control logic
// around it decides which entries are meaningful.
module fifo_mem #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the incoming word into the addressed slot.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/result_fifo_stage.sv
// Result FIFO stage: captures producer words, buffers them in a show-ahead
// FIFO and presents them over valid/ready. Words arriving while the FIFO is
// full and not being drained are dropped and counted.
module result_fifo_stage
  import result_fifo_stage_pkg::*;
#(
  parameter int WIDTH = RES_WIDTH,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8,
  localparam int AW   = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] rd_data;
  logic             pop;
  logic             push_ok;
  logic             drop;

  // Status flags come straight from the pointer registers.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level     = wr_ptr_q - rd_ptr_q;
  assign out_valid = !empty;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign pop     = out_valid && out_ready;
  assign push_ok = in_valid && (!full || pop);
  assign drop    = in_valid && full && !pop;

  // While empty the head is meaningless; show the last word read (0 after
  // reset) so the output never carries uninitialised memory.
  assign out_data = out_valid ? rd_data : hold_q;
  assign drop_cnt = drop_cnt_q;
  assign overflow = overflow_q;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_ok && rst),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  // Next-state for pointers, hold word and drop statistics.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    hold_d     = hold_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      hold_d   = rd_data;
    end

    // A drop in the same cycle as a clear wins: the count restarts at one.
    if (drop) begin
      overflow_d = 1'b1;
      if (stat_clr) begin
        drop_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (drop_cnt_q != CNT_MAX) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end else if (stat_clr) begin
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      hold_q     <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      hold_q     <= hold_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_result_fifo_stage.sv
// Bench for result_fifo_stage: scoreboard queue of expected words plus a
// cycle model for level and drop statistics, and a second instance with a
// 2-bit drop counter for saturation.
module tb_result_fifo_stage;
  import result_fifo_stage_pkg::*;

  logic         clk;
  logic         rst;
  logic         in_valid;
  result_word_t in_data;
  logic         out_valid;
  logic         out_ready;
  result_word_t out_data;
  logic [3:0]   level;
  logic         full;
  logic         empty;
  logic         stat_clr;
  logic [7:0]   drop_cnt;
  logic         overflow;

  logic         s_in_valid;
  result_word_t s_in_data;
  logic         s_out_valid;
  logic         s_out_ready;
  result_word_t s_out_data;
  logic [3:0]   s_level;
  logic         s_full;
  logic         s_empty;
  logic         s_stat_clr;
  logic [1:0]   s_drop_cnt;
  logic         s_overflow;

  int checks;
  int failures;

  result_word_t exp_q[$];
  int  mlevel;
  int  mdrop;
  bit  movf;
  bit  model_valid;

  result_fifo_stage #(.WIDTH(12), .DEPTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .full(full), .empty(empty), .stat_clr(stat_clr),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  result_fifo_stage #(.WIDTH(12), .DEPTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .level(s_level), .full(s_full), .empty(s_empty), .stat_clr(s_stat_clr),
    .drop_cnt(s_drop_cnt), .overflow(s_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Cycle model of the main instance: compare current state, then advance
  // the model by what the upcoming edge should do with the current inputs.
  always @(negedge clk) begin
    bit pop_e, full_e, acc, drp;
    if (model_valid) begin
      check("out_valid", 32'(out_valid), 32'(mlevel != 0));
      check("level",     32'(level),     32'(mlevel));
      check("full",      32'(full),      32'(mlevel == 8));
      check("empty",     32'(empty),     32'(mlevel == 0));
      check("drop_cnt",  32'(drop_cnt),  32'(mdrop));
      check("overflow",  32'(overflow),  32'(movf));
    end
    if (!rst) begin
      exp_q.delete();
      mlevel = 0;
      mdrop = 0;
      movf = 0;
      model_valid = 1;
    end else if (model_valid) begin
      full_e = (mlevel == 8);
      pop_e  = (mlevel > 0) && out_ready;
      acc    = in_valid && (!full_e || pop_e);
      drp    = in_valid && full_e && !pop_e;
      if (pop_e) begin
        check("head_data", 32'(out_data), 32'(exp_q[0]));
        $display("pop  data=%h", out_data);
        void'(exp_q.pop_front());
        mlevel--;
      end
      if (acc) begin
        exp_q.push_back(in_data);
        mlevel++;
        $display("push data=%h", in_data);
      end
      if (drp) begin
        $display("drop data=%h", in_data);
        movf = 1;
        if (stat_clr) mdrop = 1;
        else if (mdrop < 255) mdrop++;
      end else if (stat_clr) begin
        mdrop = 0;
        movf = 0;
      end
    end
  end

  task automatic step(input bit v, input result_word_t d, input bit r, input bit c);
    @(posedge clk); #1;
    in_valid = v; in_data = d; out_ready = r; stat_clr = c;
  endtask

  task automatic s_step(input bit v, input result_word_t d, input bit c);
    @(posedge clk); #1;
    s_in_valid = v; s_in_data = d; s_out_ready = 1'b0; s_stat_clr = c;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    in_valid = 0; out_ready = 1; stat_clr = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      if (empty) done = 1;
    end
    out_ready = 0;
    check("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    checks = 0; failures = 0; model_valid = 0;
    rst = 0; in_valid = 0; in_data = '0; out_ready = 0; stat_clr = 0;
    s_in_valid = 0; s_in_data = '0; s_out_ready = 0; s_stat_clr = 0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    check("rst_empty",    32'(empty),     32'd1);
    check("rst_full",     32'(full),      32'd0);
    check("rst_level",    32'(level),     32'd0);
    check("rst_out_valid",32'(out_valid), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt),  32'd0);
    check("rst_overflow", 32'(overflow),  32'd0);
    check("rst_out_data", 32'(out_data),  32'd0);

    // Order and latency
    step(1, 12'h001, 0, 0);
    check("lat_no_bypass", 32'(out_valid), 32'd0);
    step(1, 12'h002, 0, 0);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data",  32'(out_data),  32'h001);
    step(1, 12'h003, 0, 0);
    step(0, 12'h000, 0, 0);
    check("order_level", 32'(level), 32'd3);
    check("order_head",  32'(out_data), 32'h001);
    drain();
    check("order_empty", 32'(empty), 32'd1);

    // Fill and drop
    for (int i = 0; i < 11; i++) step(1, 12'(12'h100 + i), 0, 0);
    step(0, 12'h000, 0, 0);
    check("fill_full",     32'(full),     32'd1);
    check("fill_level",    32'(level),    32'd8);
    check("fill_drop_cnt", 32'(drop_cnt), 32'd3);
    check("fill_overflow", 32'(overflow), 32'd1);
    drain();

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) step(1, 12'(12'h200 + i), 0, 0);
    step(1, 12'hABC, 1, 0);
    step(0, 12'h000, 0, 0);
    check("pp_level",    32'(level),    32'd8);
    check("pp_drop_cnt", 32'(drop_cnt), 32'd3);
    check("pp_head",     32'(out_data), 32'h201);
    drain();

    // Clear statistics on the main instance
    step(0, 12'h000, 0, 1);
    step(0, 12'h000, 0, 0);
    check("clr_drop_cnt", 32'(drop_cnt), 32'd0);
    check("clr_overflow", 32'(overflow), 32'd0);

    // Saturation and clear with a 2-bit counter
    for (int i = 0; i < 13; i++) s_step(1, 12'(12'h300 + i), 0);
    s_step(0, 12'h000, 0);
    check("sat_full",     32'(s_full),     32'd1);
    check("sat_drop_cnt", 32'(s_drop_cnt), 32'd3);
    check("sat_overflow", 32'(s_overflow), 32'd1);
    s_step(0, 12'h000, 1);
    s_step(0, 12'h000, 0);
    check("sclr_drop_cnt", 32'(s_drop_cnt), 32'd0);
    check("sclr_overflow", 32'(s_overflow), 32'd0);
    check("sclr_level",    32'(s_level),    32'd8);
    s_step(1, 12'h3FF, 1);
    s_step(0, 12'h000, 0);
    check("sdrop_drop_cnt", 32'(s_drop_cnt), 32'd1);
    check("sdrop_overflow", 32'(s_overflow), 32'd1);
    check("sdrop_head",     32'(s_out_data), 32'h300);

    // Reset mid-stream (pointers have already wrapped)
    for (int i = 0; i < 5; i++) step(1, 12'(12'h400 + i), 0, 0);
    @(posedge clk); #1;
    rst = 0; in_valid = 1; in_data = 12'h777; out_ready = 0;
    @(posedge clk); #1;
    rst = 1; in_valid = 0;
    check("mid_level", 32'(level), 32'd0);
    check("mid_empty", 32'(empty), 32'd1);
    step(1, 12'h5A5, 0, 0);
    step(0, 12'h000, 0, 0);
    check("mid_level1", 32'(level),    32'd1);
    check("mid_data",   32'(out_data), 32'h5A5);
    drain();

    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
